i2s_tx_stream: RTL and testbench

//  Parametrised I2S transmitter: buffers stereo sample frames in a FIFO and serialises them as BCLK/LRCLK/SDATA.
//  All I2S timing is derived from the single system clock.

---
 rtl/i2s_tx_pkg.sv | 35 +++
 rtl/i2s_sample_fifo.sv | 53 +++++
 rtl/i2s_tx_stream.sv | 166 ++++++++++++++++
 tb/tb_i2s_tx_stream.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tx_pkg.sv
// Shared types and helpers for the I2S transmitter: FSM encoding, derived widths, frame packing.
package i2s_tx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned MAX_SLOT_W = 64;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int unsigned fill_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Left-justify each sample in its slot and concatenate {L, pad, R, pad}.
    function automatic logic [2*MAX_SLOT_W-1:0] pack_frame(
        input logic [MAX_SLOT_W-1:0] l,
        input logic [MAX_SLOT_W-1:0] r,
        input int unsigned           pad_w,
        input int unsigned           slot_w
    );
        logic [MAX_SLOT_W-1:0]   l_slot;
        logic [MAX_SLOT_W-1:0]   r_slot;
        logic [2*MAX_SLOT_W-1:0] f;
        l_slot = l << pad_w;
        r_slot = r << pad_w;
        f = ({{MAX_SLOT_W{1'b0}}, l_slot} << slot_w) | {{MAX_SLOT_W{1'b0}}, r_slot};
        return f;
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous frame FIFO with first-word-fall-through read and occupancy count.
module i2s_sample_fifo
    import i2s_tx_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic                      i_pop,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [fill_w(DEPTH)-1:0]  o_count,
    output logic                      o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = fill_w(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/i2s_tx_stream.sv
// I2S transmitter: FIFO-buffered stereo frames serialised as BCLK/LRCLK/SDATA from the system clock.
// Define I2S_TX_HOLD_LAST_EN to repeat the last popped frame on underrun instead of muting.
module i2s_tx_stream
    import i2s_tx_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned SLOT_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BCLK_HALF  = 8,
    parameter int unsigned LOW_WATER  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          in_valid,
    input  logic [2*SAMPLE_W-1:0]         in_data,
    output logic                          in_ready,
    output logic [fill_w(FIFO_DEPTH)-1:0] fill,
    output logic                          refill_req,
    output logic                          underrun,
    input  logic                          underrun_clr,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata
);

    localparam int unsigned DATA_W  = 2 * SAMPLE_W;
    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned CNT_W   = fill_w(FIFO_DEPTH);
    localparam int unsigned PH_W    = clog2_min1(BCLK_HALF);
    localparam int unsigned B_W     = clog2_min1(FRAME_W);
    localparam logic [B_W-1:0] B_LAST = B_W'(FRAME_W - 1);

    state_e             r_state;
    logic [PH_W-1:0]    r_phase;
    logic [B_W-1:0]     r_b;
    logic               r_bclk;
    logic               r_lrclk;
    logic               r_sdata;
    logic               r_dly;
    logic [FRAME_W-1:0] r_shift;
    logic               r_underrun;
    logic               r_refill;

    logic [DATA_W-1:0]  w_rdata;
    logic [DATA_W-1:0]  w_src;
    logic [FRAME_W-1:0] w_frame;
    logic [CNT_W-1:0]   w_fill;
    logic               w_empty;
    logic               w_push;
    logic               w_wrap;
    logic               w_load;
    logic               w_pop;
    logic [B_W-1:0]     w_b_next;

    assign in_ready = (w_fill < CNT_W'(FIFO_DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_wrap   = (r_phase == PH_W'(BCLK_HALF - 1));
    assign w_b_next = (r_b == B_LAST) ? '0 : r_b + B_W'(1);
    // A load happens on the fall entering b=0 while still enabled.
    assign w_load   = (r_state == ST_RUN) && w_wrap && r_bclk && (r_b == B_LAST) && enable;
    assign w_pop    = w_load && !w_empty;

    i2s_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (w_fill),
        .o_empty (w_empty)
    );

`ifdef I2S_TX_HOLD_LAST_EN
    logic [DATA_W-1:0] r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= w_rdata;
        end
    end

    assign w_src = w_empty ? r_last : w_rdata;
`else
    assign w_src = w_empty ? '0 : w_rdata;
`endif

    assign w_frame = FRAME_W'(pack_frame(MAX_SLOT_W'(w_src[DATA_W-1:SAMPLE_W]),
                                         MAX_SLOT_W'(w_src[SAMPLE_W-1:0]),
                                         SLOT_W - SAMPLE_W, SLOT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_b        <= B_LAST;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b1;
            r_sdata    <= 1'b0;
            r_dly      <= 1'b0;
            r_shift    <= '0;
            r_underrun <= 1'b0;
            r_refill   <= 1'b0;
        end else begin
            r_phase  <= w_wrap ? '0 : r_phase + PH_W'(1);
            r_refill <= (w_fill <= CNT_W'(LOW_WATER)) && (r_state == ST_RUN);

            // A fresh underrun wins over a same-cycle clear.
            if (w_load && w_empty) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_wrap && enable) begin
                        r_state <= ST_RUN;
                        r_bclk  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_wrap) begin
                        r_bclk <= !r_bclk;
                        if (r_bclk) begin
                            if ((r_b == B_LAST) && !enable) begin
                                r_state <= ST_IDLE;
                                r_b     <= B_LAST;
                                r_lrclk <= 1'b1;
                                r_sdata <= 1'b0;
                                r_dly   <= 1'b0;
                            end else begin
                                r_b     <= w_b_next;
                                r_lrclk <= (w_b_next >= B_W'(SLOT_W));
                                // sdata lags the frame by one BCLK through r_dly.
                                r_sdata <= r_dly;
                                if (r_b == B_LAST) begin
                                    r_dly   <= w_frame[FRAME_W-1];
                                    r_shift <= w_frame << 1;
                                end else begin
                                    r_dly   <= r_shift[FRAME_W-1];
                                    r_shift <= r_shift << 1;
                                end
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fill       = w_fill;
    assign refill_req = r_refill;
    assign underrun   = r_underrun;
    assign bclk       = r_bclk;
    assign lrclk      = r_lrclk;
    assign sdata      = r_sdata;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Directed bench for i2s_tx_stream: framing, FIFO flow control, underrun and reset behaviour.
module tb_i2s_tx_stream;

    localparam int unsigned SW    = 16;
    localparam int unsigned SL    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BH    = 2;
    localparam int unsigned LW    = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [2:0]  fill;
    logic        refill_req;
    logic        underrun;
    logic        underrun_clr;
    logic        bclk;
    logic        lrclk;
    logic        sdata;

    int n_tests = 0;
    int n_fail  = 0;

    i2s_tx_stream #(
        .SAMPLE_W   (SW),
        .SLOT_W     (SL),
        .FIFO_DEPTH (DEPTH),
        .BCLK_HALF  (BH),
        .LOW_WATER  (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .fill         (fill),
        .refill_req   (refill_req),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata)
    );

    always #5 clk = ~clk;

    // Receiver model: samples sdata on BCLK rises, frame starts one BCLK after LRCLK falls.
    logic [31:0] q_frames[$];
    logic [31:0] acc = '0;
    int          k = 0;
    bit          pend = 0;
    logic        p_bclk = 1'b0;
    logic        p_lr = 1'b1;
    int          idle_cnt = 0;
    int          lr_run = 0;
    int          lr_low_len = 0;
    int          lr_high_len = 0;
    time         last_rise_t = 0;
    time         bclk_per_t = 0;

    always @(negedge clk) begin
        if (rst) begin
            k    = 0;
            pend = 0;
        end else begin
            if (bclk == p_bclk) idle_cnt++;
            else idle_cnt = 0;
            if (idle_cnt > 2 * BH) k = 0;
            if (p_lr && !lrclk) pend = 1;
            if (lrclk != p_lr) begin
                if (p_lr) lr_high_len = lr_run;
                else lr_low_len = lr_run;
                lr_run = 1;
            end else begin
                lr_run++;
            end
            if (!p_bclk && bclk) begin
                bclk_per_t  = $time - last_rise_t;
                last_rise_t = $time;
                if (k >= 1) begin
                    acc = {acc[30:0], sdata};
                    k++;
                    if (k == 33) begin
                        q_frames.push_back(acc);
                        k = 0;
                    end
                end
                if (pend) begin
                    k    = 1;
                    pend = 0;
                end
            end
        end
        p_bclk = bclk;
        p_lr   = lrclk;
    end

    task automatic do_reset;
        rst          = 1'b1;
        enable       = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        underrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q_frames.delete();
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (q_frames.size() >= n) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_fill(input logic [2:0] v, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (fill == v) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_lr(input logic v, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (lrclk == v) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_tests++;
        if ({bclk, lrclk, sdata} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_pins: got %b want 010", {bclk, lrclk, sdata});
        end
        n_tests++;
        if (fill !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_fill: got %0d want 0", fill);
        end
        n_tests++;
        if ({in_ready, refill_req, underrun} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 100", {in_ready, refill_req, underrun});
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if ({bclk, lrclk, sdata} !== 3'b010) begin
            n_fail++;
            $display("FAIL idle_hold: got %b want 010", {bclk, lrclk, sdata});
        end
    endtask

    task automatic test_serialise;
        bit ok;
        do_reset();
        push(32'hA5F0_0F0F);
        push(32'h1234_8001);
        enable = 1'b1;
        wait_frames(2, 1000, ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL ser_timeout: got %0d frames want 2", q_frames.size());
        end
        if (ok) begin
            n_tests++;
            if (q_frames[0] !== 32'hA5F0_0F0F) begin
                n_fail++;
                $display("FAIL ser_frame0: got %h want a5f00f0f", q_frames[0]);
            end
            n_tests++;
            if (q_frames[1] !== 32'h1234_8001) begin
                n_fail++;
                $display("FAIL ser_frame1: got %h want 12348001", q_frames[1]);
            end
        end
        n_tests++;
        if (bclk_per_t !== time'(40)) begin
            n_fail++;
            $display("FAIL bclk_period: got %0t want 40", bclk_per_t);
        end
        n_tests++;
        if (lr_low_len !== 64 || lr_high_len !== 64) begin
            n_fail++;
            $display("FAIL lrclk_len: got low %0d high %0d want 64/64", lr_low_len, lr_high_len);
        end
        enable = 1'b0;
        repeat (300) @(negedge clk);
    endtask

    task automatic test_fifo_full;
        bit ok;
        logic [31:0] exp5;
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h1111_0000 + 32'(i));
        n_tests++;
        if (fill !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got fill %0d ready %b want 4/0", fill, in_ready);
        end
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        repeat (10) @(negedge clk);
        n_tests++;
        if (fill !== 3'd4 || refill_req !== 1'b0) begin
            n_fail++;
            $display("FAIL full_hold: got fill %0d refill %b want 4/0", fill, refill_req);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        wait_frames(5, 1500, ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL full_timeout: got %0d frames want 5", q_frames.size());
        end
`ifdef I2S_TX_HOLD_LAST_EN
        exp5 = 32'h1111_0003;
`else
        exp5 = 32'h0;
`endif
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (q_frames[i] !== 32'h1111_0000 + 32'(i)) begin
                    n_fail++;
                    $display("FAIL full_order%0d: got %h want %h", i, q_frames[i], 32'h1111_0000 + 32'(i));
                end
            end
            n_tests++;
            if (q_frames[4] !== exp5) begin
                n_fail++;
                $display("FAIL full_fifth: got %h want %h", q_frames[4], exp5);
            end
        end
        enable = 1'b0;
        repeat (300) @(negedge clk);
    endtask

    task automatic test_underrun;
        bit ok;
        logic [31:0] exp3;
        do_reset();
        push(32'hCAFE_1234);
        push(32'h8001_7FFE);
        enable = 1'b1;
        wait_fill(3'd1, 300, ok);
        n_tests++;
        if (ok !== 1'b1 || refill_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ur_first_pop: got ok %b refill %b want 1/0", ok, refill_req);
        end
        @(negedge clk);
        n_tests++;
        if (refill_req !== 1'b1 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ur_refill: got refill %b underrun %b want 1/0", refill_req, underrun);
        end
        wait_frames(3, 1000, ok);
        enable = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
        exp3 = 32'h8001_7FFE;
`else
        exp3 = 32'h0;
`endif
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL ur_timeout: got %0d frames want 3", q_frames.size());
        end
        if (ok) begin
            n_tests++;
            if (q_frames[0] !== 32'hCAFE_1234 || q_frames[1] !== 32'h8001_7FFE) begin
                n_fail++;
                $display("FAIL ur_frames: got %h %h want cafe1234 80017ffe", q_frames[0], q_frames[1]);
            end
            n_tests++;
            if (q_frames[2] !== exp3) begin
                n_fail++;
                $display("FAIL ur_third: got %h want %h", q_frames[2], exp3);
            end
        end
        n_tests++;
        if (underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ur_flag: got %b want 1", underrun);
        end
        repeat (300) @(negedge clk);
        n_tests++;
        if (underrun !== 1'b1 || refill_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ur_sticky: got underrun %b refill %b want 1/0", underrun, refill_req);
        end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        n_tests++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ur_clear: got %b want 0", underrun);
        end
    endtask

    task automatic test_push_at_pop;
        bit ok;
        do_reset();
        push(32'h0A0A_1111);
        push(32'h0B0B_2222);
        push(32'h0C0C_3333);
        enable = 1'b1;
        wait_fill(3'd2, 300, ok);
        wait_lr(1'b1, 300, ok);
        // Next pop is 16 BCLK (64 clk) after the LRCLK rise.
        repeat (63) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0D0D_4444;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (lrclk !== 1'b0 || fill !== 3'd2) begin
            n_fail++;
            $display("FAIL pp_fill: got lrclk %b fill %0d want 0/2", lrclk, fill);
        end
        wait_frames(4, 1000, ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_timeout: got %0d frames want 4", q_frames.size());
        end
        if (ok) begin
            n_tests++;
            if (q_frames[0] !== 32'h0A0A_1111 || q_frames[1] !== 32'h0B0B_2222 ||
                q_frames[2] !== 32'h0C0C_3333 || q_frames[3] !== 32'h0D0D_4444) begin
                n_fail++;
                $display("FAIL pp_order: got %h %h %h %h want 0a0a1111 0b0b2222 0c0c3333 0d0d4444",
                         q_frames[0], q_frames[1], q_frames[2], q_frames[3]);
            end
        end
        enable = 1'b0;
        repeat (300) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit  ok;
        time t0;
        do_reset();
        push(32'hFFFF_FFFF);
        push(32'hFFFF_FFFF);
        enable = 1'b1;
        wait_fill(3'd1, 300, ok);
        wait_lr(1'b1, 300, ok);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bclk, lrclk, sdata} !== 3'b010 || fill !== 3'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got pins %b fill %0d ready %b want 010/0/1",
                     {bclk, lrclk, sdata}, fill, in_ready);
        end
        rst    = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        push(32'h1357_2468);
        push(32'h2468_ACE0);
        push(32'h55AA_33CC);
        enable = 1'b1;
        wait_fill(3'd2, 300, ok);
        t0 = $time;
        repeat (20) @(negedge clk);
        enable = 1'b0;
        repeat (300) @(negedge clk);
        // Last BCLK rise of the frame is at b=31, 126 clk after the pop.
        n_tests++;
        if (last_rise_t - t0 !== time'(1260)) begin
            n_fail++;
            $display("FAIL stop_complete: got %0t want 1260", last_rise_t - t0);
        end
        n_tests++;
        if ({bclk, lrclk, sdata} !== 3'b010 || fill !== 3'd2) begin
            n_fail++;
            $display("FAIL stop_idle: got pins %b fill %0d want 010/2", {bclk, lrclk, sdata}, fill);
        end
        q_frames.delete();
        enable = 1'b1;
        wait_frames(2, 1000, ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_timeout: got %0d frames want 2", q_frames.size());
        end
        if (ok) begin
            n_tests++;
            if (q_frames[0] !== 32'h2468_ACE0 || q_frames[1] !== 32'h55AA_33CC) begin
                n_fail++;
                $display("FAIL restart_frames: got %h %h want 2468ace0 55aa33cc", q_frames[0], q_frames[1]);
            end
        end
        enable = 1'b0;
        repeat (300) @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        underrun_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_serialise();
        test_fifo_full();
        test_underrun();
        test_push_at_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
